alu1: RTL and testbench
=======================

Name: alu1

Overview:
- Registered 1-bit arithmetic/logic unit, parameterizable to WIDTH bits (default 1).
- 2-bit select (S1,S0) picks one of four functions: logic OR-with-complement, invert, increment, or full add with carry-in.
- Outputs F and CarryOut are registered on the clock.
- The block is a leaf slice, usable standalone or chained via CarryIn/CarryOut.

Parameters:
- WIDTH, 1, operand/result width in bits; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- S1  input  1  function select, MSB.
- S0  input  1  function select, LSB.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CarryIn  input  1  carry into bit 0; used only by op 11.
- F  output  WIDTH  registered result.
- CarryOut  output  1  registered carry out of MSB.

Behaviour:
- Function table, combinational, with the result captured at the next rising clk edge:
  - {S1,S0}=00: F = A | ~B (bitwise logical OR with complement, not arithmetic); CarryOut = 0.
  - {S1,S0}=01: F = ~A (bitwise); CarryOut = 0.
  - {S1,S0}=10: {CarryOut,F} = A + 1 (arithmetic); CarryIn ignored. For WIDTH=1: F = ~A, CarryOut = A.
  - {S1,S0}=11: {CarryOut,F} = A + B + CarryIn (arithmetic, WIDTH+1-bit sum). For WIDTH=1 this is a full adder.
- All inputs are sampled at the rising edge of clk. Latency is exactly 1 cycle: the edge that samples the inputs updates F/CarryOut.
- Outputs are held between edges and change only on clock edges.
- Reset, synchronous: if reset=1 at a rising edge, F <= 0 and CarryOut <= 0, and inputs are ignored that cycle.
- Reset has priority over every op. The first edge with reset=0 registers the current inputs.
- After power-up and before the first reset edge, outputs are undefined. The bench must apply reset first.
- No handshake; a new op is accepted every cycle (throughput 1/cycle).
- Carry semantics:
  - Arithmetic wraps modulo 2^WIDTH in F; the overflow bit goes to CarryOut.
  - Logic ops force CarryOut to 0 regardless of CarryIn.
  - CarryIn has no effect in ops 00, 01 and 10.
- X/Z on S1/S0 is not required to be handled; inputs are assumed to be known values when reset=0.

Decomposition:
- Shared package alu1_pkg:
  - op-select localparams OP_OR_NOTB=2'b00, OP_NOTA=2'b01, OP_INC=2'b10, OP_ADD=2'b11;
  - default WIDTH constant.
- One natural sub-module, alu1_full_adder: 1-bit sum/carry cell, instantiated WIDTH times as a ripple chain for ops 10/11. For op 10, B=0 and carry-in=1.
- The top-level alu1 contains the op mux and the output registers.

Test Plan:
- Reset: drive reset=1 with A=1,B=1,CarryIn=1,{S1,S0}=11 for one edge -> F=0, CarryOut=0. Deassert -> the next edge gives F=1, CarryOut=1.
- Exhaustive sweep for WIDTH=1: {S1,S0,A,B,CarryIn}=0..31, one vector per cycle -> each result appears one cycle later. Examples:
  - 00,A=0,B=1 -> F=0,CO=0;
  - 00,A=0,B=0 -> F=1,CO=0;
  - 01,A=1 -> F=0,CO=0.
- Increment for WIDTH=1:
  - {S1,S0}=10,A=1,CarryIn=0 -> F=0, CarryOut=1;
  - A=0,CarryIn=1 -> F=1, CarryOut=0 (CarryIn ignored).
- Full add for WIDTH=1: {S1,S0}=11:
  - A=1,B=0,CarryIn=1 -> F=0, CarryOut=1;
  - A=0,B=0,CarryIn=1 -> F=1, CarryOut=0.
- Back-to-back with reset mid-stream: ops 11 then 01 then reset=1 then 10 on consecutive edges -> outputs follow each op 1 cycle later, the reset cycle yields 0/0, and nothing from the pre-reset stream leaks out.
- WIDTH=4:
  - op 11, A=4'hF,B=4'h1,CarryIn=0 -> F=4'h0, CarryOut=1;
  - op 10, A=4'h7 -> F=4'h8, CarryOut=0;
  - op 00, A=4'h5,B=4'hC -> F=4'h7, CarryOut=0.

Source files
------------

// File: rtl/alu1_pkg.sv
// Shared definitions for the alu1 slice: function-select codes and default width.
package alu1_pkg;

  localparam int DEFAULT_WIDTH = 1;

  localparam logic [1:0] OP_OR_NOTB = 2'b00;
  localparam logic [1:0] OP_NOTA    = 2'b01;
  localparam logic [1:0] OP_INC     = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b11;

endpackage

// File: rtl/alu1_if.sv
// Operand/select/result bundle for alu1; master drives operands, slave returns results.
interface alu1_if #(parameter int WIDTH = 1);

  logic             S1;
  logic             S0;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CarryIn;
  logic [WIDTH-1:0] F;
  logic             CarryOut;

  modport master (output S1, S0, A, B, CarryIn, input F, CarryOut);
  modport slave  (input S1, S0, A, B, CarryIn, output F, CarryOut);

endinterface

// File: rtl/alu1_full_adder.sv
// One-bit sum/carry cell; alu1 chains these into a ripple adder.
module alu1_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/alu1.sv
// Registered WIDTH-bit ALU slice: OR-with-complement, invert, increment, add with carry.
module alu1
  import alu1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic  clk,
  input  logic  reset,
  alu1_if.slave bus
);

  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_addB;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_nextF;
  logic             w_nextCo;
  logic [WIDTH-1:0] r_f;
  logic             r_co;

  assign w_op = {bus.S1, bus.S0};

  // Increment reuses the adder chain with B forced to zero and a carry-in of one.
  assign w_addB     = (w_op == OP_INC) ? '0 : bus.B;
  assign w_carry[0] = (w_op == OP_INC) ? 1'b1 : bus.CarryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    alu1_full_adder u_fa (
      .i_a    (bus.A[i]),
      .i_b    (w_addB[i]),
      .i_cin  (w_carry[i]),
      .o_sum  (w_sum[i]),
      .o_cout (w_carry[i+1])
    );
  end

  always_comb begin
    w_nextF  = '0;
    w_nextCo = 1'b0;
    case (w_op)
      OP_OR_NOTB: w_nextF = bus.A | ~bus.B;
      OP_NOTA:    w_nextF = ~bus.A;
      OP_INC,
      OP_ADD: begin
        w_nextF  = w_sum;
        w_nextCo = w_carry[WIDTH];
      end
      default: begin
        w_nextF  = '0;
        w_nextCo = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f  <= '0;
      r_co <= 1'b0;
    end else begin
      r_f  <= w_nextF;
      r_co <= w_nextCo;
    end
  end

  assign bus.F        = r_f;
  assign bus.CarryOut = r_co;

endmodule

// File: tb/tb_alu1.sv
// Self-checking bench for alu1 at WIDTH=1 and WIDTH=4 against an arithmetic reference model.
module tb_alu1;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [3:0] exp4F;
  logic       exp4Co;
  logic       exp1F;
  logic       exp1Co;

  alu1_if #(.WIDTH(1)) bus1 ();
  alu1_if #(.WIDTH(4)) bus4 ();

  alu1 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  alu1 #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: function table evaluated with integer arithmetic, result split at bit WIDTH.
  function automatic logic [4:0] refModel(input logic rst, input logic [1:0] op,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input int width);
    int mask;
    int av;
    int bv;
    int r;
    logic [4:0] res;
    mask = (1 << width) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    r    = 0;
    if (!rst) begin
      case (op)
        2'd0:    r = (av | ~bv) & mask;
        2'd1:    r = ~av & mask;
        2'd2:    r = av + 1;
        default: r = av + bv + int'(cin);
      endcase
    end
    res      = 5'd0;
    res[3:0] = 4'(r & mask);
    res[4]   = ((r >> width) & 1) != 0;
    return res;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [1:0] op,
                               input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] r1;
    logic [4:0] r4;
    @(negedge clk);
    reset        = rst;
    bus1.S1      = op[1];
    bus1.S0      = op[0];
    bus1.A       = a[0];
    bus1.B       = b[0];
    bus1.CarryIn = cin;
    bus4.S1      = op[1];
    bus4.S0      = op[0];
    bus4.A       = a;
    bus4.B       = b;
    bus4.CarryIn = cin;
    r1     = refModel(rst, op, a, b, cin, 1);
    r4     = refModel(rst, op, a, b, cin, 4);
    exp1F  = r1[0];
    exp1Co = r1[4];
    exp4F  = r4[3:0];
    exp4Co = r4[4];
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (bus1.F === exp1F) else begin
      miscompares++;
      $error("[TB] FAIL %s w1.F observed=%b expected=%b", tag, bus1.F, exp1F);
    end
    assert (bus1.CarryOut === exp1Co) else begin
      miscompares++;
      $error("[TB] FAIL %s w1.CarryOut observed=%b expected=%b", tag, bus1.CarryOut, exp1Co);
    end
    assert (bus4.F === exp4F) else begin
      miscompares++;
      $error("[TB] FAIL %s w4.F observed=%h expected=%h", tag, bus4.F, exp4F);
    end
    assert (bus4.CarryOut === exp4Co) else begin
      miscompares++;
      $error("[TB] FAIL %s w4.CarryOut observed=%b expected=%b", tag, bus4.CarryOut, exp4Co);
    end
  endtask

  initial begin
    logic [4:0] vv;
    logic [3:0] hi;
    logic       held1F;
    logic [3:0] held4F;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;

    // Reset with all-ones add pending, then first live edge registers it.
    applyStimulus(1'b1, 2'b11, 4'h1, 4'h1, 1'b1);
    checkOutput("reset");
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h1, 1'b1);
    checkOutput("post_reset");

    for (int v = 0; v < 32; v++) begin
      vv = v[4:0];
      hi = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, vv[4:3], {hi[3:1], vv[2]}, {hi[2:0], vv[1]}, vv[0]);
      checkOutput($sformatf("sweep%0d", v));
    end

    applyStimulus(1'b0, 2'b10, 4'h1, 4'h0, 1'b0);
    checkOutput("inc_a1");
    applyStimulus(1'b0, 2'b10, 4'h0, 4'h0, 1'b1);
    checkOutput("inc_a0_cin");
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h0, 1'b1);
    checkOutput("add_101");
    applyStimulus(1'b0, 2'b11, 4'h0, 4'h0, 1'b1);
    checkOutput("add_001");

    applyStimulus(1'b0, 2'b11, 4'hF, 4'h1, 1'b0);
    checkOutput("w4_add_wrap");
    applyStimulus(1'b0, 2'b10, 4'h7, 4'h0, 1'b0);
    checkOutput("w4_inc7");
    applyStimulus(1'b0, 2'b00, 4'h5, 4'hC, 1'b1);
    checkOutput("w4_or_notb");

    applyStimulus(1'b0, 2'b11, 4'h9, 4'h8, 1'b1);
    checkOutput("b2b_add");
    applyStimulus(1'b0, 2'b01, 4'h3, 4'h0, 1'b1);
    checkOutput("b2b_nota");
    applyStimulus(1'b1, 2'b11, 4'hF, 4'hF, 1'b1);
    checkOutput("b2b_reset");
    applyStimulus(1'b0, 2'b10, 4'hE, 4'h0, 1'b1);
    checkOutput("b2b_inc");

    // Outputs must not move between edges even when inputs change.
    held1F = bus1.F;
    held4F = bus4.F;
    @(negedge clk);
    bus1.A = ~bus1.A;
    bus4.A = ~bus4.A;
    #2;
    vectors++;
    assert (bus1.F === held1F && bus4.F === held4F) else begin
      miscompares++;
      $error("[TB] FAIL hold observed=%b/%h expected=%b/%h", bus1.F, bus4.F, held1F, held4F);
    end

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
